// File: rtl/gray_decoder_monitor.sv
// Gray-code sampler/decoder with +1 step integrity checking, lock tracking,
// sticky wrap flag and saturating error count. Optional macro: GRAY_STRICT_STEP_EN.
module gray_decoder_monitor #(
   parameter int unsigned WIDTH  = 3,
   parameter int unsigned LOCK_N = 2,
   parameter int unsigned ERR_W  = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             En,
   input  logic [WIDTH-1:0] GrayIn,
   output logic [WIDTH-1:0] Output,
   output logic             Valid,
   output logic             Locked,
   output logic             StepErr,
   output logic             Overflow,
   output logic [ERR_W-1:0] ErrCount
);

   localparam int unsigned GOOD_W = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);

   localparam logic [1:0] EMPTY  = 2'd0;
   localparam logic [1:0] SEARCH = 2'd1;
   localparam logic [1:0] LOCKED = 2'd2;

`ifdef GRAY_STRICT_STEP_EN
   localparam bit STRICT_REPEAT = 1'b1;
`else
   localparam bit STRICT_REPEAT = 1'b0;
`endif

   logic [1:0]        state, state_nxt;
   logic [GOOD_W-1:0] good, good_nxt, good_inc;
   logic [WIDTH-1:0]  out_nxt, d, nxt;
   logic              valid_nxt, locked_nxt, steperr_nxt, overflow_nxt;
   logic [ERR_W-1:0]  err_nxt;

   // MSB-first prefix XOR turns Gray into binary
   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b = g;
      for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   assign d        = gray2bin(GrayIn);
   assign nxt      = Output + WIDTH'(1);
   assign good_inc = good + GOOD_W'(1);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= EMPTY;
         good     <= '0;
         Output   <= '0;
         Valid    <= 1'b0;
         Locked   <= 1'b0;
         StepErr  <= 1'b0;
         Overflow <= 1'b0;
         ErrCount <= '0;
      end else begin
         state    <= state_nxt;
         good     <= good_nxt;
         Output   <= out_nxt;
         Valid    <= valid_nxt;
         Locked   <= locked_nxt;
         StepErr  <= steperr_nxt;
         Overflow <= overflow_nxt;
         ErrCount <= err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      good_nxt     = good;
      out_nxt      = Output;
      valid_nxt    = Valid;
      locked_nxt   = Locked;
      steperr_nxt  = 1'b0;
      overflow_nxt = Overflow;
      err_nxt      = ErrCount;

      if (En) begin
         out_nxt = d;
         case (state)
            EMPTY: begin
               valid_nxt = 1'b1;
               good_nxt  = '0;
               state_nxt = SEARCH;
            end
            SEARCH: begin
               if (d == nxt) begin
                  if (good_inc == GOOD_W'(LOCK_N)) begin
                     state_nxt  = LOCKED;
                     locked_nxt = 1'b1;
                     good_nxt   = '0;
                  end else begin
                     good_nxt = good_inc;
                  end
               end else if (d == Output) begin
                  if (STRICT_REPEAT) good_nxt = '0;
               end else begin
                  // resynchronise on the new sample without flagging an error
                  good_nxt = '0;
               end
            end
            LOCKED: begin
               if (d == nxt) begin
                  if (Output == '1) overflow_nxt = 1'b1;
               end else if (d == Output && !STRICT_REPEAT) begin
                  // source may hold its value between strobes
                  state_nxt = LOCKED;
               end else begin
                  steperr_nxt = 1'b1;
                  if (ErrCount != '1) err_nxt = ErrCount + ERR_W'(1);
                  state_nxt  = SEARCH;
                  good_nxt   = '0;
                  locked_nxt = 1'b0;
               end
            end
            default: begin
               state_nxt = EMPTY;
            end
         endcase
      end
   end

endmodule
